// File: rtl/ifu_if.sv
// ifu_if: fetch-unit bus bundle covering the instruction-memory port, the IDU handshake and the commit/BRU feedback.
interface ifu_if #(parameter int CPU_WIDTH = 32);
    logic                 o_imem_req_valid;
    logic                 i_imem_req_ready;
    logic [CPU_WIDTH-1:0] o_imem_addr;
    logic                 i_imem_rsp_valid;
    logic [31:0]          i_imem_rsp_data;
    logic                 i_imem_rsp_err;
    logic                 o_ifu_valid;
    logic                 i_idu_ready;
    logic [31:0]          o_ifu_inst;
    logic [CPU_WIDTH-1:0] o_ifu_pc;
    logic                 i_commit;
    logic [CPU_WIDTH-1:0] i_bru_next_pc;
    logic                 o_ifu_fault;
    logic [1:0]           o_ifu_fault_cause;
    modport master (
        output o_imem_req_valid, o_imem_addr, o_ifu_valid, o_ifu_inst, o_ifu_pc, o_ifu_fault, o_ifu_fault_cause,
        input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_imem_rsp_err, i_idu_ready, i_commit, i_bru_next_pc
    );
    modport slave (
        input  o_imem_req_valid, o_imem_addr, o_ifu_valid, o_ifu_inst, o_ifu_pc, o_ifu_fault, o_ifu_fault_cause,
        output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_imem_rsp_err, i_idu_ready, i_commit, i_bru_next_pc
    );
endinterface

// File: rtl/ifu.sv
// ifu: non-pipelined instruction fetch unit owning the PC, with one fetch in flight,
// response timeout and sticky fault reporting.
module ifu #(
    parameter int                   CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(32'h8000_0000),
    parameter int                   TIMEOUT   = 255
) (
    input logic i_clk,
    input logic i_rst,
    ifu_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DISP, EXEC, FAULT} state_t;
    state_t               state;
    logic [CPU_WIDTH-1:0] pc;
    logic [7:0]           cnt;
    logic [31:0]          inst;
    logic                 req_valid, ifu_valid, fault;
    logic [1:0]           cause;
    logic                 commit_ok, misaligned;
    // A commit is honoured in EXEC, or in DISP when it coincides with the IDU handshake
    assign commit_ok  = bus.i_commit && (state == EXEC || (state == DISP && bus.i_idu_ready));
    assign misaligned = |bus.i_bru_next_pc[1:0];
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            inst      <= 32'h0000_0013;
            cnt       <= '0;
            req_valid <= 1'b0;
            ifu_valid <= 1'b0;
            fault     <= 1'b0;
            cause     <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    state     <= REQ;
                    req_valid <= 1'b1;
                end
                REQ: if (bus.i_imem_req_ready) begin
                    state     <= WAIT;
                    req_valid <= 1'b0;
                    cnt       <= '0;
                end
                WAIT: if (bus.i_imem_rsp_valid && bus.i_imem_rsp_err) begin
                    state <= FAULT;
                    fault <= 1'b1;
                    cause <= 2'd1;
                end else if (bus.i_imem_rsp_valid) begin
                    state     <= DISP;
                    inst      <= bus.i_imem_rsp_data;
                    ifu_valid <= 1'b1;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    state <= FAULT;
                    fault <= 1'b1;
                    cause <= 2'd2;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                DISP: if (bus.i_idu_ready) begin
                    state     <= EXEC;
                    ifu_valid <= 1'b0;
                end
                default: ;
            endcase
            if (commit_ok) begin
                ifu_valid <= 1'b0;
                if (misaligned) begin
                    state <= FAULT;
                    fault <= 1'b1;
                    cause <= 2'd3;
                end else begin
                    state     <= REQ;
                    pc        <= bus.i_bru_next_pc;
                    req_valid <= 1'b1;
                end
            end
        end
    end
    assign bus.o_imem_req_valid  = req_valid;
    assign bus.o_imem_addr       = pc;
    assign bus.o_ifu_valid       = ifu_valid;
    assign bus.o_ifu_inst        = inst;
    assign bus.o_ifu_pc          = pc;
    assign bus.o_ifu_fault       = fault;
    assign bus.o_ifu_fault_cause = cause;
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed self-checking bench for ifu with a 4-cycle response timeout.
module tb_ifu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    localparam logic [31:0] RST_PC = 32'h8000_0000;
    ifu_if #(.CPU_WIDTH(32)) b ();
    ifu #(.CPU_WIDTH(32), .RESET_PC(RST_PC), .TIMEOUT(4)) dut (.i_clk(clk), .i_rst(rst), .bus(b));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 32'(b.o_imem_req_valid), 32'd0);
        chk({tag, "_addr"}, b.o_imem_addr, RST_PC);
        chk({tag, "_ifu_valid"}, 32'(b.o_ifu_valid), 32'd0);
        chk({tag, "_inst"}, b.o_ifu_inst, 32'h0000_0013);
        chk({tag, "_pc"}, b.o_ifu_pc, RST_PC);
        chk({tag, "_fault"}, 32'(b.o_ifu_fault), 32'd0);
        chk({tag, "_cause"}, 32'(b.o_ifu_fault_cause), 32'd0);
    endtask
    initial begin
        b.i_imem_req_ready = 0;
        b.i_imem_rsp_valid = 0;
        b.i_imem_rsp_data  = '0;
        b.i_imem_rsp_err   = 0;
        b.i_idu_ready      = 0;
        b.i_commit         = 0;
        b.i_bru_next_pc    = '0;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 0;
        tick();
        chk("req_after_idle", 32'(b.o_imem_req_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            b.i_imem_rsp_valid = (i == 2);
            b.i_imem_rsp_data  = 32'hDEAD_BEEF;
            chk("stall_req_valid", 32'(b.o_imem_req_valid), 32'd1);
            chk("stall_addr", b.o_imem_addr, RST_PC);
            tick();
        end
        b.i_imem_rsp_valid = 0;
        chk("stray_rsp_ignored", b.o_ifu_inst, 32'h0000_0013);
        b.i_imem_req_ready = 1;
        tick();
        b.i_imem_req_ready = 0;
        chk("wait_req_dropped", 32'(b.o_imem_req_valid), 32'd0);
        b.i_imem_rsp_valid = 1;
        b.i_imem_rsp_data  = 32'h0000_0093;
        tick();
        b.i_imem_rsp_valid = 0;
        chk("disp_valid", 32'(b.o_ifu_valid), 32'd1);
        chk("disp_inst", b.o_ifu_inst, 32'h0000_0093);
        chk("disp_pc", b.o_ifu_pc, RST_PC);
        tick();
        chk("disp_hold_valid", 32'(b.o_ifu_valid), 32'd1);
        chk("disp_hold_inst", b.o_ifu_inst, 32'h0000_0093);
        b.i_idu_ready = 1;
        tick();
        b.i_idu_ready = 0;
        chk("exec_valid_low", 32'(b.o_ifu_valid), 32'd0);
        chk("exec_no_req", 32'(b.o_imem_req_valid), 32'd0);
        b.i_commit = 1;
        b.i_bru_next_pc = 32'h8000_0004;
        tick();
        b.i_commit = 0;
        chk("commit_req", 32'(b.o_imem_req_valid), 32'd1);
        chk("commit_addr", b.o_imem_addr, 32'h8000_0004);
        chk("commit_pc", b.o_ifu_pc, 32'h8000_0004);
        b.i_imem_req_ready = 1;
        tick();
        b.i_imem_req_ready = 0;
        b.i_imem_rsp_valid = 1;
        b.i_imem_rsp_data  = 32'h0010_0113;
        tick();
        b.i_imem_rsp_valid = 0;
        chk("fast_inst", b.o_ifu_inst, 32'h0010_0113);
        b.i_idu_ready = 1;
        b.i_commit = 1;
        b.i_bru_next_pc = 32'h8000_0010;
        tick();
        b.i_idu_ready = 0;
        b.i_commit = 0;
        chk("fast_req", 32'(b.o_imem_req_valid), 32'd1);
        chk("fast_addr", b.o_imem_addr, 32'h8000_0010);
        chk("fast_valid_low", 32'(b.o_ifu_valid), 32'd0);
        b.i_imem_req_ready = 1;
        tick();
        b.i_imem_req_ready = 0;
        b.i_imem_rsp_valid = 1;
        b.i_imem_rsp_data  = 32'h0000_0055;
        tick();
        b.i_imem_rsp_valid = 0;
        b.i_idu_ready = 1;
        tick();
        b.i_idu_ready = 0;
        b.i_commit = 1;
        b.i_bru_next_pc = 32'h8000_0102;
        tick();
        b.i_commit = 0;
        chk("misalign_fault", 32'(b.o_ifu_fault), 32'd1);
        chk("misalign_cause", 32'(b.o_ifu_fault_cause), 32'd3);
        chk("misalign_pc", b.o_ifu_pc, 32'h8000_0010);
        chk("misalign_req", 32'(b.o_imem_req_valid), 32'd0);
        b.i_commit = 1;
        b.i_bru_next_pc = 32'h8000_0020;
        b.i_imem_req_ready = 1;
        tick();
        tick();
        b.i_commit = 0;
        b.i_imem_req_ready = 0;
        chk("fault_pc_frozen", b.o_ifu_pc, 32'h8000_0010);
        chk("fault_no_req", 32'(b.o_imem_req_valid), 32'd0);
        chk("fault_sticky", 32'(b.o_ifu_fault), 32'd1);
        rst = 1;
        tick();
        chk_reset_outputs("fault_reset");
        rst = 0;
        tick();
        b.i_imem_req_ready = 1;
        tick();
        b.i_imem_req_ready = 0;
        tick();
        b.i_imem_rsp_valid = 1;
        b.i_imem_rsp_err = 1;
        b.i_imem_rsp_data = 32'h0000_0077;
        tick();
        b.i_imem_rsp_valid = 0;
        b.i_imem_rsp_err = 0;
        chk("buserr_fault", 32'(b.o_ifu_fault), 32'd1);
        chk("buserr_cause", 32'(b.o_ifu_fault_cause), 32'd1);
        chk("buserr_valid", 32'(b.o_ifu_valid), 32'd0);
        chk("buserr_inst", b.o_ifu_inst, 32'h0000_0013);
        rst = 1;
        tick();
        rst = 0;
        tick();
        b.i_imem_req_ready = 1;
        tick();
        b.i_imem_req_ready = 0;
        tick();
        tick();
        tick();
        chk("timeout_not_yet", 32'(b.o_ifu_fault), 32'd0);
        tick();
        chk("timeout_fault", 32'(b.o_ifu_fault), 32'd1);
        chk("timeout_cause", 32'(b.o_ifu_fault_cause), 32'd2);
        b.i_imem_req_ready = 1;
        tick();
        tick();
        b.i_imem_req_ready = 0;
        chk("timeout_no_req", 32'(b.o_imem_req_valid), 32'd0);
        rst = 1;
        tick();
        rst = 0;
        tick();
        b.i_imem_req_ready = 1;
        tick();
        b.i_imem_req_ready = 0;
        tick();
        tick();
        tick();
        b.i_imem_rsp_valid = 1;
        b.i_imem_rsp_data = 32'h0000_00AB;
        tick();
        b.i_imem_rsp_valid = 0;
        chk("late_rsp_no_fault", 32'(b.o_ifu_fault), 32'd0);
        chk("late_rsp_valid", 32'(b.o_ifu_valid), 32'd1);
        chk("late_rsp_inst", b.o_ifu_inst, 32'h0000_00AB);
        b.i_idu_ready = 1;
        b.i_commit = 1;
        b.i_bru_next_pc = 32'h8000_0040;
        tick();
        b.i_idu_ready = 0;
        b.i_commit = 0;
        chk("late_commit_addr", b.o_imem_addr, 32'h8000_0040);
        b.i_imem_req_ready = 1;
        tick();
        b.i_imem_req_ready = 0;
        rst = 1;
        tick();
        chk_reset_outputs("wait_reset");
        rst = 0;
        tick();
        chk("restart_req", 32'(b.o_imem_req_valid), 32'd1);
        chk("restart_addr", b.o_imem_addr, RST_PC);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
